// File: rtl/red_serial_unit.sv
// Nibble-serial RED reduction: sums the eight 4-bit nibbles of A and B with one narrow adder over four cycles.
// Define RED_UNSIGNED_EN to treat nibbles as unsigned and zero-extend the result.
module red_serial_unit #(
  parameter int NIBBLES_PER_OP = 4,
  parameter int ACC_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] S,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  // Handshake: an operation is accepted on a clock edge where in_valid && in_ready;
  // a result is consumed on a clock edge where out_valid && out_ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int IDX_W = (NIBBLES_PER_OP > 1) ? $clog2(NIBBLES_PER_OP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES_PER_OP - 1);

  state_t           state;
  state_t           state_next;
  logic [15:0]      a_sh;
  logic [15:0]      b_sh;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [IDX_W-1:0] idx;
  logic [15:0]      s_q;
  logic [15:0]      s_ext;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The low nibble of each shift register is always the pair being added this cycle.
  always_comb begin
`ifdef RED_UNSIGNED_EN
    a_ext = {{(ACC_W-4){1'b0}}, a_sh[3:0]};
    b_ext = {{(ACC_W-4){1'b0}}, b_sh[3:0]};
`else
    a_ext = {{(ACC_W-4){a_sh[3]}}, a_sh[3:0]};
    b_ext = {{(ACC_W-4){b_sh[3]}}, b_sh[3:0]};
`endif
    acc_next = acc + a_ext + b_ext;
`ifdef RED_UNSIGNED_EN
    s_ext = {{(16-ACC_W){1'b0}}, acc_next};
`else
    s_ext = {{(16-ACC_W){acc_next[ACC_W-1]}}, acc_next};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      idx  <= '0;
      s_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= A;
            b_sh <= B;
            acc  <= '0;
            idx  <= '0;
          end
        end
        ACCUM: begin
          acc  <= acc_next;
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          idx  <= idx + 1'b1;
          // S only changes when the final sum lands, so it is stable through DONE and after.
          if (idx == LAST_IDX) s_q <= s_ext;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign S         = s_q;
  assign fsm_state = state;

endmodule
